// File: rtl/mod_md_sched.sv
// Multiply/divide scheduler: runs mult/multu (and div/divu when MOD_MD_SCHED_DIV_EN
// is defined), holds the result for a fixed latency, then commits it to HI/LO.
module mod_md_sched #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] opnd_a,
   input  logic [31:0] opnd_b,
   input  logic        rd_req,
   output logic        busy,
   output logic        stall_req,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state, state_next;
   logic [4:0]  cnt;
   logic [31:0] pend_hi, pend_lo;
   logic        is_mul, is_div, accept, mt_hi, mt_lo, last;
   logic [4:0]  lat;
   logic [63:0] ext_a, ext_b, prod;
   logic [31:0] res_hi, res_lo;

`ifdef MOD_MD_SCHED_DIV_EN
   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b, uq, ur;
`endif

   // Decode, operation result and FSM next-state; the result is only captured on accept.
   always_comb begin
      is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MOD_MD_SCHED_DIV_EN
      is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
`else
      is_div = 1'b0;
`endif
      accept = (state == IDLE) && start && (is_mul || is_div);
      mt_hi  = (state == IDLE) && start && (md_op == OP_MTHI);
      mt_lo  = (state == IDLE) && start && (md_op == OP_MTLO);
      last   = (state == BUSY) && (cnt == 5'd1);
      lat    = is_mul ? 5'(MULT_LAT) : 5'(DIV_LAT);

      ext_a  = (md_op == OP_MULT) ? {{32{opnd_a[31]}}, opnd_a} : {32'd0, opnd_a};
      ext_b  = (md_op == OP_MULT) ? {{32{opnd_b[31]}}, opnd_b} : {32'd0, opnd_b};
      prod   = ext_a * ext_b;
      res_hi = prod[63:32];
      res_lo = prod[31:0];

`ifdef MOD_MD_SCHED_DIV_EN
      // Signed division via magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
      neg_a = (md_op == OP_DIV) && opnd_a[31];
      neg_b = (md_op == OP_DIV) && opnd_b[31];
      mag_a = neg_a ? (32'd0 - opnd_a) : opnd_a;
      mag_b = neg_b ? (32'd0 - opnd_b) : opnd_b;
      uq    = mag_a / ((mag_b == 32'd0) ? 32'd1 : mag_b);
      ur    = mag_a % ((mag_b == 32'd0) ? 32'd1 : mag_b);
      if (is_div) begin
         if (opnd_b == 32'd0) begin
            res_lo = 32'hFFFF_FFFF;
            res_hi = opnd_a;
         end else begin
            res_lo = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
            res_hi = neg_a ? (32'd0 - ur) : ur;
         end
      end
`endif

      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (last)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, latency counter, pending result and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= 5'd0;
         done    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
      end else begin
         state <= state_next;
         done  <= last;
         if (accept) begin
            cnt     <= lat;
            pend_hi <= res_hi;
            pend_lo <= res_lo;
         end else if (state == BUSY) begin
            cnt <= cnt - 5'd1;
         end
         if (last) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
         if (mt_hi) hi <= opnd_a;
         if (mt_lo) lo <= opnd_a;
      end
   end

   assign busy      = (state == BUSY);
   assign stall_req = busy & (start | rd_req);

endmodule

// File: tb/tb_mod_md_sched.sv
// Directed self-checking bench for mod_md_sched; divider checks follow MOD_MD_SCHED_DIV_EN.
module tb_mod_md_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] opnd_a, opnd_b;
   logic        rd_req;
   logic        busy, stall_req, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   mod_md_sched dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .opnd_a(opnd_a), .opnd_b(opnd_b), .rd_req(rd_req),
      .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic rd);
      start  = s;
      md_op  = op;
      opnd_a = a;
      opnd_b = b;
      rd_req = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts busy cycles until busy falls, bounded so a stuck DUT cannot hang the run.
   task automatic waitIdle(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   int n, sc, g;
   logic done_seen;

   initial begin
      reset = 1'b0;
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_hi", hi, 0);
      checkOutput("rst_lo", lo, 0);
      applyStimulus(1'b1, 3'b000, 32'd0, 32'd0, 1'b1);
      #1;
      checkOutput("rst_stall", stall_req, 0);

      // signed mult, operands scrambled after accept
      applyStimulus(1'b1, 3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      waitIdle(n);
      checkOutput("mult_cycles", n, 5);
      checkOutput("mult_done", done, 1);
      checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
      checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
      tick();
      checkOutput("mult_done_drop", done, 0);

      applyStimulus(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      waitIdle(n);
      checkOutput("multu_cycles", n, 5);
      checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
      checkOutput("multu_lo", lo, 32'h0000_0001);

      // rd_req plus mtlo arriving in busy cycle 2 must stall, then land after commit
      applyStimulus(1'b1, 3'b001, 32'd2, 32'd3, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 3'b110, 32'h0000_1234, 32'd0, 1'b1);
      #1;
      sc = 0;
      g = 0;
      while (busy && g < 40) begin
         if (stall_req) sc++;
         tick();
         g++;
      end
      checkOutput("stall_cycles", sc, 4);
      checkOutput("stall_clear", stall_req, 0);
      checkOutput("held_lo_commit", lo, 32'd6);
      checkOutput("held_hi_commit", hi, 32'd0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      checkOutput("mtlo_applied", lo, 32'h0000_1234);
      checkOutput("mtlo_no_busy", busy, 0);
      checkOutput("mtlo_no_done", done, 0);

      // back-to-back start in the done cycle
      applyStimulus(1'b1, 3'b001, 32'd5, 32'd7, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      waitIdle(n);
      checkOutput("b2b_first_done", done, 1);
      checkOutput("b2b_first_lo", lo, 32'd35);
      applyStimulus(1'b1, 3'b010, 32'h10, 32'h10, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      checkOutput("b2b_no_gap", busy, 1);
      waitIdle(n);
      checkOutput("b2b_cycles", n, 5);
      checkOutput("b2b_second_lo", lo, 32'h100);

      // mthi/mtlo, then reserved/none ops must leave everything untouched
      applyStimulus(1'b1, 3'b101, 32'h0000_AAAA, 32'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 3'b110, 32'h0000_5555, 32'd0, 1'b0);
      tick();
      checkOutput("mthi", hi, 32'h0000_AAAA);
      checkOutput("mtlo", lo, 32'h0000_5555);
      applyStimulus(1'b1, 3'b111, 32'hDEAD_BEEF, 32'd1, 1'b0);
      tick();
      checkOutput("op7_busy", busy, 0);
      checkOutput("op7_hi", hi, 32'h0000_AAAA);
      applyStimulus(1'b1, 3'b000, 32'hDEAD_BEEF, 32'd1, 1'b0);
      tick();
      checkOutput("op0_busy", busy, 0);
      checkOutput("op0_lo", lo, 32'h0000_5555);

`ifdef MOD_MD_SCHED_DIV_EN
      applyStimulus(1'b1, 3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      waitIdle(n);
      checkOutput("div_cycles", n, 10);
      checkOutput("div_lo", lo, 32'hFFFF_FFFD);
      checkOutput("div_hi", hi, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 3'b100, 32'd9, 32'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      waitIdle(n);
      checkOutput("divu0_lo", lo, 32'hFFFF_FFFF);
      checkOutput("divu0_hi", hi, 32'd9);
      applyStimulus(1'b1, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      waitIdle(n);
      checkOutput("divovf_lo", lo, 32'h8000_0000);
      checkOutput("divovf_hi", hi, 32'd0);
`else
      applyStimulus(1'b1, 3'b011, 32'd8, 32'd2, 1'b0);
      tick();
      checkOutput("nodiv_busy", busy, 0);
      checkOutput("nodiv_stall", stall_req, 0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      checkOutput("nodiv_busy2", busy, 0);
      checkOutput("nodiv_hi", hi, 32'h0000_AAAA);
      checkOutput("nodiv_lo", lo, 32'h0000_5555);
`endif

      // reset during busy cycle 3 aborts without a later commit
      applyStimulus(1'b1, 3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_hi", hi, 0);
      checkOutput("abort_lo", lo, 0);
      done_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) done_seen = 1'b1;
      end
      checkOutput("abort_no_done", done_seen, 0);
      checkOutput("abort_late_hi", hi, 0);
      checkOutput("abort_late_lo", lo, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mod_md_sched.md
MOD_MD_SCHED -- requirements
Module: mod_md_sched

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5; busy cycles for mult/multu (range 1..31).
REQ-002 SHALL have parameter DIV_LAT, default 10; busy cycles for div/divu (range 1..31).
REQ-003 SHALL have port clk, input, 1; sole clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1; synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1; E-stage holds a multiply/divide-class instruction this cycle.
REQ-006 SHALL have port md_op, input, 3; 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved.
REQ-007 SHALL have ports opnd_a and opnd_b, input, 32 each; forwarded rs and rt values.
REQ-008 SHALL have port rd_req, input, 1; E-stage holds mfhi/mflo this cycle.
REQ-009 SHALL have port busy, output, 1; an operation is in flight.
REQ-010 SHALL have port stall_req, output, 1; combinational request to freeze D/E.
REQ-011 SHALL have port done, output, 1; one-cycle pulse when HI/LO commit.
REQ-012 SHALL have ports hi and lo, output, 32 each; architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM IDLE/BUSY; a start is accepted only in IDLE with start=1 and md_op in 001..100 (IDLE->BUSY).
REQ-014 SHALL compute the result at acceptance from opnd_a/opnd_b into pending registers; later operand changes are ignored.
REQ-015 SHALL produce mult as signed 64-bit and multu as unsigned 64-bit products; HI=upper, LO=lower 32 bits.
REQ-016 SHALL produce div/divu quotient in LO and remainder in HI; signed remainder takes the dividend's sign.
REQ-017 SHALL, on divisor 0, give LO=0xFFFFFFFF and HI=opnd_a; on signed 0x80000000/0xFFFFFFFF, give LO=0x80000000 and HI=0.
REQ-018 SHALL load a down-counter with the op's LAT on accept; busy=1 for exactly LAT cycles after the accept edge.
REQ-019 SHALL, on the edge ending the last busy cycle, write pending into hi/lo, return to IDLE, drop busy, and assert done for the following cycle only.
REQ-020 SHALL write mthi (opnd_a->hi) or mtlo (opnd_a->lo) on the accept edge in IDLE without entering BUSY or pulsing done.
REQ-021 SHALL drive stall_req = busy & (start | rd_req); an operation presented while busy is neither accepted nor lost, and is accepted the cycle busy is 0.
REQ-022 SHALL treat md_op 000/111 with start=1 as no-op: no state change, stall_req still follows REQ-021.
REQ-023 SHALL allow a back-to-back start in the cycle done=1, entering BUSY again with no idle gap.

Reset
REQ-024 SHALL, when reset=0 at a rising edge, set FSM to IDLE, counter 0, busy 0, done 0, hi 0, lo 0, pending 0, aborting any in-flight operation without commit.
REQ-025 SHALL hold stall_req at 0 in the cycle after a reset edge, because busy is then 0.

Configuration
REQ-026 SHALL gate the divider with macro MOD_MD_SCHED_DIV_EN; when defined, div/divu follow REQ-016..019.
REQ-027 SHALL, when MOD_MD_SCHED_DIV_EN is undefined, omit divider logic and treat div/divu as no-ops per REQ-022 (hi/lo unchanged, busy stays 0).

Verification
REQ-028 SHALL cover: mult a=0xFFFFFFFE b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle.
REQ-029 SHALL cover: multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-030 SHALL cover: div a=-7 b=2 -> 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu b=0 -> lo=0xFFFFFFFF, hi=a.
REQ-031 SHALL cover: rd_req=1 in busy cycle 2 -> stall_req=1 until busy falls; mtlo 0x1234 while busy -> held, lo=0x1234 the edge after busy clears.
REQ-032 SHALL cover: reset=0 in busy cycle 3 of mult -> next cycle busy=0, done=0, hi=lo=0, no later commit.
REQ-033 SHALL cover: build without MOD_MD_SCHED_DIV_EN, div 8/2 -> busy stays 0, hi/lo unchanged, stall_req 0.
